// File: rtl/im_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter: default widths,
// FSM state encoding and the port identifiers used by the round-robin logic.
package im_arb_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 32;

   // Port identifiers; also the encoding of the round-robin last-winner bit
   localparam logic PORT_F = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/im_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins; on a tie the
// port that did not win last time is chosen. Output is one-hot or zero.
module im_arb_rr
   import im_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // Tie-break against the last winner, otherwise pass the single request through
   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt = (last == PORT_F) ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/im_arbiter.sv
// Instruction-memory arbiter sharing one combinational-read memory between a
// fetch port and a debug/loader port. Grant in IDLE/RESP, memory read in READ,
// response pulse in RESP (grant-to-rvalid latency 2 cycles).
// Optional build macro IM_ARB_ALIGN_CHECK_EN: misaligned grants return zero
// data together with an err pulse instead of reading memory.
module im_arbiter
   import im_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              err
);

   state_t            state;
   logic [ADDR_W-1:0] addr_reg;
   logic              port_reg;
   logic              last_reg;
   logic              f_rvalid_reg;
   logic              d_rvalid_reg;
   logic [DATA_W-1:0] f_rdata_reg;
   logic [DATA_W-1:0] d_rdata_reg;
   logic [1:0]        rr_gnt;
   logic [1:0]        gnt;
   logic              grant_ok;
   logic              any_gnt;
   logic              win;

`ifdef IM_ARB_ALIGN_CHECK_EN
   logic              mis_reg;
   logic              mis_next;
   logic              err_reg;
`endif

   im_arb_rr u_rr (
      .req  ({d_req, f_req}),
      .last (last_reg),
      .gnt  (rr_gnt)
   );

   // Grants are only offered when the FSM can start a new read; held low in reset
   assign grant_ok = rst_n && ((state == IDLE) || (state == RESP));
   assign gnt      = grant_ok ? rr_gnt : 2'b00;
   assign any_gnt  = |gnt;
   assign win      = gnt[1];
   assign f_gnt    = gnt[0];
   assign d_gnt    = gnt[1];

   assign mem_addr = addr_reg;
   assign busy     = (state != IDLE);
   assign f_rvalid = f_rvalid_reg;
   assign d_rvalid = d_rvalid_reg;
   assign f_rdata  = f_rdata_reg;
   assign d_rdata  = d_rdata_reg;

`ifdef IM_ARB_ALIGN_CHECK_EN
   assign mis_next = ((win == PORT_D) ? d_addr[1:0] : f_addr[1:0]) != 2'b00;
   assign err      = err_reg;
`else
   assign err      = 1'b0;
`endif

   // Arbitration FSM: latch the winner's address, read in READ, respond in RESP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         addr_reg     <= '0;
         port_reg     <= PORT_F;
         last_reg     <= PORT_D;
         f_rvalid_reg <= 1'b0;
         d_rvalid_reg <= 1'b0;
         f_rdata_reg  <= '0;
         d_rdata_reg  <= '0;
`ifdef IM_ARB_ALIGN_CHECK_EN
         mis_reg      <= 1'b0;
         err_reg      <= 1'b0;
`endif
      end else begin
         f_rvalid_reg <= 1'b0;
         d_rvalid_reg <= 1'b0;
`ifdef IM_ARB_ALIGN_CHECK_EN
         err_reg      <= 1'b0;
`endif
         if (any_gnt) begin
            addr_reg <= (win == PORT_D) ? d_addr : f_addr;
            port_reg <= win;
            last_reg <= win;
`ifdef IM_ARB_ALIGN_CHECK_EN
            mis_reg  <= mis_next;
`endif
         end
         case (state)
            IDLE: begin
               if (any_gnt) state <= READ;
            end
            READ: begin
               state <= RESP;
`ifdef IM_ARB_ALIGN_CHECK_EN
               err_reg <= mis_reg;
               if (port_reg == PORT_F) begin
                  f_rvalid_reg <= 1'b1;
                  f_rdata_reg  <= mis_reg ? '0 : mem_rdata;
               end else begin
                  d_rvalid_reg <= 1'b1;
                  d_rdata_reg  <= mis_reg ? '0 : mem_rdata;
               end
`else
               if (port_reg == PORT_F) begin
                  f_rvalid_reg <= 1'b1;
                  f_rdata_reg  <= mem_rdata;
               end else begin
                  d_rvalid_reg <= 1'b1;
                  d_rdata_reg  <= mem_rdata;
               end
`endif
            end
            RESP: begin
               state <= any_gnt ? READ : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_im_arbiter.sv
// Scoreboard bench for im_arbiter: stimulus pushes expected responses (port,
// data, err, due cycle); a negedge monitor pops and compares on every rvalid.
module tb_im_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        f_req = 1'b0;
   logic [11:0] f_addr = '0;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        d_req = 1'b0;
   logic [11:0] d_addr = '0;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic [11:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        err;

   logic [31:0] mem [0:1023];
   assign mem_rdata = mem[mem_addr[11:2]];

   typedef struct {
      logic        port;
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] held_f = '0;
   logic [31:0] held_d = '0;

   im_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .f_req     (f_req),
      .f_addr    (f_addr),
      .f_gnt     (f_gnt),
      .f_rvalid  (f_rvalid),
      .f_rdata   (f_rdata),
      .d_req     (d_req),
      .d_addr    (d_addr),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push_exp(input logic port, input logic [31:0] data, input logic e);
      exp_t x;
      x.port = port;
      x.data = data;
      x.err  = e;
      x.cyc  = cyc + 2;
      q.push_back(x);
   endtask

   // Response monitor: every rvalid must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst_n) begin
         held_f = '0;
         held_d = '0;
      end else begin
         if (f_rvalid || d_rvalid) begin
            check("single_rvalid", {31'b0, f_rvalid & d_rvalid}, 32'd0);
            check("rvalid_expected", {31'b0, q.size() > 0}, 32'd1);
            if (q.size() > 0) begin
               mon_e = q.pop_front();
               check("resp_port", {31'b0, d_rvalid}, {31'b0, mon_e.port});
               check("resp_data", d_rvalid ? d_rdata : f_rdata, mon_e.data);
               check("resp_err", {31'b0, err}, {31'b0, mon_e.err});
               check("resp_cycle", cyc, mon_e.cyc);
               $display("resp port=%s data=%h err=%0d cycle=%0d",
                        d_rvalid ? "D" : "F", d_rvalid ? d_rdata : f_rdata, err, cyc);
            end
         end else begin
            check("err_without_rvalid", {31'b0, err}, 32'd0);
         end
         if (f_rvalid) held_f = f_rdata;
         else check("f_rdata_hold", f_rdata, held_f);
         if (d_rvalid) held_d = d_rdata;
         else check("d_rdata_hold", d_rdata, held_d);
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_gnt", {30'b0, d_gnt, f_gnt}, 32'd0);
      check("rst_rvalid", {30'b0, d_rvalid, f_rvalid}, 32'd0);
      check("rst_busy_err", {30'b0, busy, err}, 32'd0);
      check("rst_f_rdata", f_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 + i;
      mem[0]    = 32'h0000_0BAD;
      mem[1]    = 32'h1111_0001;
      mem[4]    = 32'h8C08_0004;
      mem[8]    = 32'hF0F0_0008;
      mem[12]   = 32'hD0D0_000C;
      mem[1023] = 32'hCAFE_F00D;

      do_reset();

      // Single fetch read: grant at cycle 0, data at cycle 2
      f_req = 1'b1; f_addr = 12'h010;
      @(negedge clk);
      check("t1_gnt", {30'b0, d_gnt, f_gnt}, 32'd1);
      push_exp(1'b0, 32'h8C08_0004, 1'b0);
      @(posedge clk); #1;
      f_req = 1'b0;
      @(negedge clk);
      check("t1_busy_read", {31'b0, busy}, 32'd1);
      check("t1_mem_addr", {20'b0, mem_addr}, 32'h010);
      check("t1_no_gnt_read", {30'b0, d_gnt, f_gnt}, 32'd0);
      idle_cycles(3);
      @(negedge clk);
      check("t1_idle_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;

      // Both requesting from reset: F, D, F, D every 2 cycles
      f_req = 1'b1; f_addr = 12'h020;
      d_req = 1'b1; d_addr = 12'h030;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         case (i % 4)
            0: begin
               check("t2_gnt", {30'b0, d_gnt, f_gnt}, 32'd1);
               push_exp(1'b0, 32'hF0F0_0008, 1'b0);
            end
            2: begin
               check("t2_gnt", {30'b0, d_gnt, f_gnt}, 32'd2);
               push_exp(1'b1, 32'hD0D0_000C, 1'b0);
            end
            default: check("t2_gnt", {30'b0, d_gnt, f_gnt}, 32'd0);
         endcase
         @(posedge clk); #1;
      end
      f_req = 1'b0; d_req = 1'b0;
      idle_cycles(3);

      // Debug read of the top word: no wrap to word 0
      d_req = 1'b1; d_addr = 12'hFFC;
      @(negedge clk);
      check("t3_gnt", {30'b0, d_gnt, f_gnt}, 32'd2);
      push_exp(1'b1, 32'hCAFE_F00D, 1'b0);
      @(posedge clk); #1;
      d_req = 1'b0;
      idle_cycles(3);

      // Reset during READ discards the read; next tie goes to fetch
      f_req = 1'b1; f_addr = 12'h040;
      @(negedge clk);
      check("t4_gnt", {30'b0, d_gnt, f_gnt}, 32'd1);
      @(posedge clk); #1;
      f_req = 1'b0;
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      check("t4_busy_in_reset", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("t4_busy_after", {31'b0, busy}, 32'd0);
      idle_cycles(3);
      f_req = 1'b1; f_addr = 12'h010;
      d_req = 1'b1; d_addr = 12'h030;
      @(negedge clk);
      check("t4_tie_gnt", {30'b0, d_gnt, f_gnt}, 32'd1);
      push_exp(1'b0, 32'h8C08_0004, 1'b0);
      @(posedge clk); #1;
      f_req = 1'b0; d_req = 1'b0;
      idle_cycles(3);

      // Misaligned fetch address
      f_req = 1'b1; f_addr = 12'h006;
      @(negedge clk);
      check("t5_gnt", {30'b0, d_gnt, f_gnt}, 32'd1);
`ifdef IM_ARB_ALIGN_CHECK_EN
      push_exp(1'b0, 32'h0000_0000, 1'b1);
`else
      push_exp(1'b0, 32'h1111_0001, 1'b0);
`endif
      @(posedge clk); #1;
      f_req = 1'b0;
      idle_cycles(3);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      check("queue_drained", q.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
